pipe_ctrl: RTL

//  Pipeline control unit for the 5-stage MIPS32 core. Merges stall requests from
//  IF/ID/EX/MEM into the 6-bit stall vector (bit0=PC, 1=IF, 2=ID, 3=EX, 4=MEM, 5=WB).

---
 rtl/pipe_ctrl_if.sv | 40 ++++
 rtl/pipe_ctrl.sv | 116 +++++++++++
 2 files changed

// File: rtl/pipe_ctrl_if.sv
// ---------------------------------------------------------------------------
// pipe_ctrl_if
// Bundles the signals exchanged between the pipeline control unit and the
// rest of the 5-stage MIPS32 core.
//   stallreq_from_if/id/ex/mem : per-stage stall requests into the controller
//   excepttype_i               : exception code from MEM stage (0 = none)
//   cp0_epc_i                  : forwarded EPC, restart address for ERET
//   cnt_clr                    : clears the stall-cycle counter
//   stall                      : 6-bit stall vector (0=PC,1=IF,2=ID,3=EX,4=MEM,5=WB)
//   flush / new_pc             : registered one-cycle flush pulse and restart PC
//   stall_cycles               : saturating count of PC-stall cycles
// Modports: slave = the controller, master = the core / environment side.
// ---------------------------------------------------------------------------
interface pipe_ctrl_if #(
    parameter int CNT_W = 16
);
    logic              stallreq_from_if;
    logic              stallreq_from_id;
    logic              stallreq_from_ex;
    logic              stallreq_from_mem;
    logic [31:0]       excepttype_i;
    logic [31:0]       cp0_epc_i;
    logic              cnt_clr;
    logic [5:0]        stall;
    logic              flush;
    logic [31:0]       new_pc;
    logic [CNT_W-1:0]  stall_cycles;

    modport slave (
        input  stallreq_from_if, stallreq_from_id, stallreq_from_ex,
               stallreq_from_mem, excepttype_i, cp0_epc_i, cnt_clr,
        output stall, flush, new_pc, stall_cycles
    );

    modport master (
        output stallreq_from_if, stallreq_from_id, stallreq_from_ex,
               stallreq_from_mem, excepttype_i, cp0_epc_i, cnt_clr,
        input  stall, flush, new_pc, stall_cycles
    );
endinterface

// File: rtl/pipe_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_ctrl
// Pipeline control unit for the 5-stage MIPS32 core. Merges stage stall
// requests into the stall vector, sequences exceptions/ERET through a
// RUN -> HOLD -> FLUSH handshake (freeze, then a registered one-cycle flush
// carrying the restart PC), and counts PC-stall cycles with saturation.
// Ports:
//   clk  : core clock, all state on posedge
//   rst  : synchronous reset, active-high
//   bus  : pipe_ctrl_if.slave (stall requests, exception inputs, cnt_clr in;
//          stall, flush, new_pc, stall_cycles out)
// ---------------------------------------------------------------------------
module pipe_ctrl #(
    parameter logic [31:0] EXC_VECTOR = 32'h0000_0020,
    parameter int          CNT_W      = 16
) (
    input  logic        clk,
    input  logic        rst,
    pipe_ctrl_if.slave  bus
);

    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_HOLD  = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;

    localparam logic [31:0] CODE_ERET = 32'h0000_000e;

    logic [1:0]       state_q, state_d;
    logic             flush_q, flush_d;
    logic [31:0]      new_pc_q, new_pc_d;
    logic [31:0]      vec_q, vec_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [5:0]       stall;
    logic             accept;

    // Stall vector. Reset forces it low regardless of state.
    always_comb begin
        stall = 6'b000000;
        if (!rst) begin
            unique case (state_q)
                ST_RUN: begin
                    if (bus.stallreq_from_mem)     stall = 6'b011111;
                    else if (bus.stallreq_from_ex) stall = 6'b001111;
                    else if (bus.stallreq_from_id) stall = 6'b000111;
                    else if (bus.stallreq_from_if) stall = 6'b000011;
                    else                           stall = 6'b000000;
                end
                ST_HOLD:  stall = 6'b111111;
                default:  stall = 6'b000000;
            endcase
        end
    end

    // An exception is deferred while the data bus is waiting so the MEM
    // stage state is stable when it is taken.
    assign accept = (state_q == ST_RUN) && (bus.excepttype_i != 32'd0)
                    && !bus.stallreq_from_mem;

    always_comb begin
        state_d  = state_q;
        flush_d  = 1'b0;
        new_pc_d = new_pc_q;
        vec_d    = vec_q;
        unique case (state_q)
            ST_RUN: begin
                if (accept) begin
                    state_d = ST_HOLD;
                    vec_d   = (bus.excepttype_i == CODE_ERET) ? bus.cp0_epc_i
                                                              : EXC_VECTOR;
                end
            end
            ST_HOLD: begin
                state_d  = ST_FLUSH;
                flush_d  = 1'b1;
                new_pc_d = vec_q;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // Clear wins over increment; the counter sticks at all-ones.
    always_comb begin
        cnt_d = cnt_q;
        if (bus.cnt_clr)
            cnt_d = '0;
        else if (stall[0] && (cnt_q != {CNT_W{1'b1}}))
            cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_RUN;
            flush_q  <= 1'b0;
            new_pc_q <= 32'd0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            flush_q  <= flush_d;
            new_pc_q <= new_pc_d;
            cnt_q    <= cnt_d;
        end
    end

    // Only read after an accept has loaded it, so it needs no reset.
    always_ff @(posedge clk) begin
        vec_q <= vec_d;
    end

    assign bus.stall        = stall;
    assign bus.flush        = flush_q;
    assign bus.new_pc       = new_pc_q;
    assign bus.stall_cycles = cnt_q;

endmodule
